// File: rtl/matmul_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matmul_operand_feeder
// Purpose  : Transmit side of the Matrix_Multiplier operand interface. A host
//            preloads a beat buffer (data word + weight byte per beat) while
//            idle; start_i replays the whole buffer as one beat stream, flags
//            the final beat on valid_o, then waits for the multiplier's done
//            (or gives up after TIMEOUT cycles).
// Ports    : clk_i, rst_i (async, active-high)
//            wr_en_i/wr_addr_i/wr_din_i/wr_win_i : buffer write port (IDLE only)
//            start_i, pause_i, mm_done_i         : control / handshake inputs
//            en_o, valid_o, din_o, win_o         : registered multiplier drive
//            busy_o, done_o, timeout_o           : status
// Revision : 1.0 - initial release
// ============================================================================
module matmul_operand_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAC_NUM      = 8,
    parameter int K_DEPTH      = 4,
    parameter int N_COLS       = 8,
    parameter int TIMEOUT      = 255,
    localparam int NBEATS      = K_DEPTH * N_COLS,
    localparam int ADDR_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int WORD_W      = MAC_NUM * DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [WORD_W-1:0]       wr_din_i,
    input  logic [WEIGHT_WIDTH-1:0] wr_win_i,
    input  logic                    start_i,
    input  logic                    pause_i,
    input  logic                    mm_done_i,
    output logic                    en_o,
    output logic                    valid_o,
    output logic [WORD_W-1:0]       din_o,
    output logic [WEIGHT_WIDTH-1:0] win_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o
);

    localparam int                TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NBEATS - 1);
    // Timer expires on the edge at which it would reach TIMEOUT.
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STREAM    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_idx, w_idx_nxt;
    logic [TIMER_W-1:0]      r_timer, w_timer_nxt;
    logic                    r_en, w_en_nxt;
    logic                    r_valid, w_valid_nxt;
    logic [WORD_W-1:0]       r_din, w_din_nxt;
    logic [WEIGHT_WIDTH-1:0] r_win, w_win_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_timeout, w_timeout_nxt;

    // Beat buffer: deliberately not reset so contents survive a mid-stream reset.
    logic [WORD_W-1:0]       r_data_mem   [NBEATS];
    logic [WEIGHT_WIDTH-1:0] r_weight_mem [NBEATS];
    logic                    w_addr_ok;

    assign w_addr_ok = ({1'b0, wr_addr_i} < (ADDR_W + 1)'(NBEATS));

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (r_state == S_IDLE) && w_addr_ok) begin
            r_data_mem[wr_addr_i]   <= wr_din_i;
            r_weight_mem[wr_addr_i] <= wr_win_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_timer   <= '0;
            r_en      <= 1'b0;
            r_valid   <= 1'b0;
            r_din     <= '0;
            r_win     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_en      <= w_en_nxt;
            r_valid   <= w_valid_nxt;
            r_din     <= w_din_nxt;
            r_win     <= w_win_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Stream outputs default to zero every cycle, so din/win are only non-zero
    // in cycles where a beat is actually launched.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_en_nxt      = 1'b0;
        w_valid_nxt   = 1'b0;
        w_din_nxt     = '0;
        w_win_nxt     = '0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt   = S_STREAM;
                    w_idx_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_STREAM: begin
                if (!pause_i) begin
                    w_en_nxt    = 1'b1;
                    w_din_nxt   = r_data_mem[r_idx];
                    w_win_nxt   = r_weight_mem[r_idx];
                    w_valid_nxt = (r_idx == c_last_idx);
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = S_WAIT_DONE;
                        w_timer_nxt = '0;
                    end
                end
            end
            S_WAIT_DONE: begin
                // done takes priority over a coincident timer expiry
                if (mm_done_i) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                    if (r_timer == c_timer_last) begin
                        w_state_nxt   = S_IDLE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign en_o      = r_en;
    assign valid_o   = r_valid;
    assign din_o     = r_din;
    assign win_o     = r_win;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire
